// File: rtl/pc_sequencer_pkg.sv
// pc_pkg: shared state type and default widths for the PC sequencer.
package pc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALTED} pc_state_t;
    localparam int PC_W = 12;
    localparam int PC_OFF_W = 8;
    localparam int PC_CNT_W = 16;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs from decode/ALU and PC/status outputs to ROM and harness.
interface pc_sequencer_if #(
    parameter int D = pc_pkg::PC_W,
    parameter int CNT_W = pc_pkg::PC_CNT_W
);
    logic start, stall, branch, taken, abs_en, halt;
    logic [D-1:0] target;
    logic [D-1:0] prog_ctr;
    logic fetch_valid, done;
    logic [CNT_W-1:0] cyc_cnt;
    modport master (
        output start, stall, branch, taken, abs_en, target, halt,
        input prog_ctr, fetch_valid, done, cyc_cnt
    );
    modport slave (
        input start, stall, branch, taken, abs_en, target, halt,
        output prog_ctr, fetch_valid, done, cyc_cnt
    );
endinterface

// File: rtl/pc_sequencer_next_calc.sv
// pc_next_calc: branch destination, absolute target or PC plus sign-extended low offset.
module pc_next_calc
    import pc_pkg::*;
#(
    parameter int D = PC_W,
    parameter int OFF_W = PC_OFF_W
) (
    input  logic [D-1:0] prog_ctr_i,
    input  logic         abs_en_i,
    input  logic [D-1:0] target_i,
    output logic [D-1:0] dest_o
);
    logic [D-1:0] rel_dest;
    assign rel_dest = prog_ctr_i + {{(D-OFF_W){target_i[OFF_W-1]}}, target_i[OFF_W-1:0]};
    assign dest_o = abs_en_i ? target_i : rel_dest;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter FSM with fetch qualifier, done flag and saturating cycle counter.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int D = PC_W,
    parameter int OFF_W = PC_OFF_W,
    parameter int CNT_W = PC_CNT_W
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    pc_state_t state_q, state_d;
    logic [D-1:0] pc_q, pc_d, dest;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    pc_next_calc #(.D(D), .OFF_W(OFF_W)) u_next (
        .prog_ctr_i(pc_q),
        .abs_en_i  (bus.abs_en),
        .target_i  (bus.target),
        .dest_o    (dest)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE, HALTED: if (bus.start) begin
                state_d = RUN;
                pc_d = '0;
                cnt_d = '0;
            end
            RUN: if (!bus.stall) begin
                cnt_d = cnt_inc;
                if (bus.halt) state_d = HALTED;
                else if (bus.branch && bus.taken) begin
                    pc_d = dest;
                    state_d = FLUSH;
                end else pc_d = pc_q + 1'b1;
            end
            default: begin
                cnt_d = cnt_inc;
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.prog_ctr = pc_q;
    assign bus.fetch_valid = (state_q == RUN);
    assign bus.done = (state_q == HALTED);
    assign bus.cyc_cnt = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed steps with an expectation queue checked one cycle after each drive.
module tb_pc_sequencer;
    typedef struct {
        logic [11:0] pc;
        logic        fv;
        logic        dn;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 0;
    logic reset = 1;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    string tq[$];

    pc_sequencer_if bus ();
    pc_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic drive(input logic st, sl, br, tk, ab, input logic [11:0] tg, input logic hl);
        bus.start = st;
        bus.stall = sl;
        bus.branch = br;
        bus.taken = tk;
        bus.abs_en = ab;
        bus.target = tg;
        bus.halt = hl;
    endtask

    task automatic chk();
        exp_t e;
        string t;
        e = sb.pop_front();
        t = tq.pop_front();
        checks++;
        assert (bus.prog_ctr === e.pc) else begin
            errors++;
            $error("FAIL %s prog_ctr got %h exp %h", t, bus.prog_ctr, e.pc);
        end
        checks++;
        assert (bus.fetch_valid === e.fv) else begin
            errors++;
            $error("FAIL %s fetch_valid got %b exp %b", t, bus.fetch_valid, e.fv);
        end
        checks++;
        assert (bus.done === e.dn) else begin
            errors++;
            $error("FAIL %s done got %b exp %b", t, bus.done, e.dn);
        end
        checks++;
        assert (bus.cyc_cnt === e.cnt) else begin
            errors++;
            $error("FAIL %s cyc_cnt got %h exp %h", t, bus.cyc_cnt, e.cnt);
        end
    endtask

    task automatic cyc(input string tag, input logic [11:0] pc, input logic fv, dn, input logic [15:0] cnt);
        exp_t e;
        e.pc = pc;
        e.fv = fv;
        e.dn = dn;
        e.cnt = cnt;
        sb.push_back(e);
        tq.push_back(tag);
        @(posedge clk);
        #1;
        chk();
    endtask

    task automatic jump(input string tag, input logic [11:0] tg, input logic [15:0] cnt);
        drive(0, 0, 1, 1, 1, tg, 0);
        cyc({tag, "_flush"}, tg, 0, 0, cnt);
        drive(0, 0, 0, 0, 0, 12'h000, 0);
        cyc({tag, "_run"}, tg, 1, 0, cnt + 16'd1);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 12'h000, 0);
        cyc("reset", 12'h000, 0, 0, 16'd0);
        reset = 0;
        cyc("idle_hold", 12'h000, 0, 0, 16'd0);
        drive(1, 0, 0, 0, 0, 12'h000, 0);
        cyc("start", 12'h000, 1, 0, 16'd0);
        drive(0, 0, 0, 0, 0, 12'h000, 0);
        for (int i = 1; i <= 10; i++) cyc("inc", 12'(i), 1, 0, 16'(i));
        drive(0, 0, 1, 1, 0, 12'hAFC, 0);
        cyc("rel_neg_flush", 12'd6, 0, 0, 16'd11);
        drive(1, 1, 1, 1, 1, 12'h123, 1);
        cyc("flush_ignores", 12'd6, 1, 0, 16'd12);
        drive(0, 0, 0, 0, 0, 12'h000, 0);
        cyc("after_rel", 12'd7, 1, 0, 16'd13);
        jump("abs3", 12'd3, 16'd14);
        jump("abs0ff", 12'h0FF, 16'd16);
        jump("abs3b", 12'd3, 16'd18);
        drive(0, 0, 1, 0, 1, 12'h0FF, 0);
        cyc("not_taken", 12'd4, 1, 0, 16'd20);
        jump("abs20", 12'd20, 16'd21);
        drive(0, 1, 0, 0, 0, 12'h000, 0);
        for (int i = 0; i < 3; i++) cyc("stall", 12'd20, 1, 0, 16'd22);
        drive(0, 1, 1, 1, 1, 12'h055, 1);
        cyc("stall_wins", 12'd20, 1, 0, 16'd22);
        drive(0, 0, 0, 0, 0, 12'h000, 1);
        cyc("halt", 12'd20, 0, 1, 16'd23);
        cyc("halted_hold", 12'd20, 0, 1, 16'd23);
        drive(1, 0, 0, 0, 0, 12'h000, 0);
        cyc("restart", 12'd0, 1, 0, 16'd0);
        cyc("start_ignored_run", 12'd1, 1, 0, 16'd1);
        drive(0, 0, 0, 0, 0, 12'h000, 0);
        jump("absfff", 12'hFFF, 16'd2);
        cyc("wrap_inc", 12'h000, 1, 0, 16'd4);
        jump("absfff2", 12'hFFF, 16'd5);
        drive(0, 0, 1, 1, 0, 12'h001, 0);
        cyc("rel_wrap", 12'h000, 0, 0, 16'd7);
        drive(0, 0, 0, 0, 0, 12'h000, 0);
        cyc("rel_wrap_run", 12'h000, 1, 0, 16'd8);
        drive(0, 0, 1, 1, 0, 12'h005, 0);
        cyc("rel_pos", 12'h005, 0, 0, 16'd9);
        drive(0, 0, 0, 0, 0, 12'h000, 0);
        reset = 1;
        cyc("reset_in_flush", 12'h000, 0, 0, 16'd0);
        reset = 0;
        cyc("idle_after_reset", 12'h000, 0, 0, 16'd0);
        drive(1, 0, 0, 0, 0, 12'h000, 0);
        cyc("sat_start", 12'h000, 1, 0, 16'd0);
        drive(0, 0, 0, 0, 0, 12'h000, 0);
        repeat (65534) @(posedge clk);
        #1;
        cyc("sat_reach", 12'hFFF, 1, 0, 16'hFFFF);
        cyc("sat_hold", 12'h000, 1, 0, 16'hFFFF);
        drive(0, 0, 0, 0, 0, 12'h000, 1);
        cyc("sat_halt", 12'h000, 0, 1, 16'hFFFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Control FSM that sequences the program counter of the single-cycle core.
- Owns the PC register.
- Decides each cycle whether to hold, increment, take a relative or absolute branch, flush, or halt.
- Presents a fetch-valid qualifier to instruction memory.
- Counts executed cycles for the benchmark harness.
- Sits between the decoder/ALU flag logic (which produce branch/taken/halt) and instruction ROM.

Parameters:
D, 12, PC width in bits; instruction ROM depth is 2^D
OFF_W, 8, width of signed relative branch offset carried in low bits of target
CNT_W, 16, width of cycle counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin execution from PC 0 (level, sampled in IDLE/HALTED)
stall  input  1  hold PC and state for this cycle (RUN only)
branch  input  1  current instruction is a branch
taken  input  1  branch condition true (ignored unless branch=1)
abs_en  input  1  1: absolute jump to target; 0: relative, PC + sext(target[OFF_W-1:0])
target  input  D  absolute target or relative offset
halt  input  1  current instruction is halt
prog_ctr  output  D  current PC, drives instruction ROM address
fetch_valid  output  1  ROM output at prog_ctr is a live instruction this cycle
done  output  1  program finished, sticky until restart/reset
cyc_cnt  output  CNT_W  cycles spent in RUN+FLUSH since last start

Behaviour:
- Reset (synchronous, highest priority, any state):
  - prog_ctr=0, state=IDLE, fetch_valid=0, done=0, cyc_cnt=0.
  - Reset mid-branch or mid-flush discards the pending update.
- States: IDLE, RUN, FLUSH, HALTED. fetch_valid = (state==RUN). done = (state==HALTED).
- IDLE:
  - PC held at 0.
  - start=1 -> RUN next cycle; PC stays 0; cyc_cnt cleared to 0.
- RUN, per-cycle priority (highest first):
  - stall=1 -> PC, state and cyc_cnt hold; stall suppresses all other inputs that cycle.
  - halt=1 -> HALTED; PC holds at the halt address.
  - branch&taken:
    - abs_en=1 -> PC <= target.
    - abs_en=0 -> PC <= PC + sign-extend(target[OFF_W-1:0]) mod 2^D; target[D-1:OFF_W] ignored.
    - Then -> FLUSH.
  - Otherwise PC <= PC+1 mod 2^D; wraps from 2^D-1 to 0 with no error.
  - branch=1 with taken=0 behaves as increment.
  - start is ignored in RUN.
- FLUSH:
  - Exactly one cycle; PC holds the new target.
  - fetch_valid=0; inputs ignored (stall, halt and branch have no effect).
  - -> RUN.
  - Net latency: taken branch at cycle N, target instruction valid at cycle N+2.
- HALTED:
  - PC and cyc_cnt hold.
  - start=1 -> PC <= 0, cyc_cnt <= 0, -> RUN; done drops the same edge.
- cyc_cnt:
  - Increments by 1 each non-stalled RUN cycle and each FLUSH cycle.
  - Stalled cycles are not counted.
  - Saturates at 2^CNT_W-1; never wraps.
- All outputs are registered or a pure decode of the state register; no combinational path from inputs to outputs.

Decomposition:
- Shared package pc_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALTED} pc_state_t
  - localparams PC_W=12, PC_OFF_W=8, PC_CNT_W=16
- One combinational sub-module, pc_next_calc.
  - Inputs: prog_ctr, abs_en, target.
  - Output: branch destination (sign-extend, add and mux logic).
  - Unit-testable in isolation.
- The FSM, PC register and counter stay in pc_sequencer.

Test Plan:
- Reset then start with no branches for 5 cycles -> prog_ctr 0,1,2,3,4; fetch_valid=1 from the cycle after start; cyc_cnt=5.
- At PC=10, branch=1, taken=1, abs_en=0, target=8'hFC (-4) -> next PC=6; fetch_valid=0 one cycle; PC=7 the following cycle.
- At PC=3, absolute jump target=12'h0FF -> PC=0x0FF after one FLUSH cycle; branch with taken=0 at PC=3 -> PC=4, no flush.
- At PC=20, stall held 3 cycles -> PC stays 20 and cyc_cnt frozen; stall+halt together -> stall wins; halt alone -> done=1, PC=20 held, start -> PC=0, done=0.
- PC=0xFFF increment -> 0x000; relative +1 from 0xFFF -> 0x000; reset asserted during FLUSH -> IDLE, PC=0, cyc_cnt=0.
- Run past 65535 counted cycles (CNT_W=16) -> cyc_cnt saturates at 0xFFFF.
